sobel_filter: RTL

SOBEL_FILTER -- requirements
Module: sobel_filter

---
 rtl/sobel_filter_if.sv | 39 +++
 rtl/sobel_filter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/sobel_filter_if.sv
// ---------------------------------------------------------------------------
// sobel_filter_if
// Purpose : pixel-stream bundle between a window source and sobel_filter.
// Signals : vsync      - low = frame blanking
//           in_valid   - pix_window holds the next 3x3 neighbourhood
//           pix_window - NW N NE W C E SW S SE, 8 bits each, NW in the MSBs
//           threshold  - binarisation level
//           edge_pix   - saturated gradient magnitude
//           edge_bin   - edge_pix > threshold
//           out_valid  - edge_pix / edge_bin / out_addr valid
//           out_addr   - linear frame address of the output pixel
//           frame_done - one-cycle pulse with the last pixel of a frame
// Modports: master drives the window side, slave is the filter.
// ---------------------------------------------------------------------------
interface sobel_filter_if;
    localparam int unsigned PIX_W = 8;
    localparam int unsigned WIN_W = 9 * PIX_W;
    localparam int unsigned ADDR_W = 19;

    logic              vsync;
    logic              in_valid;
    logic [WIN_W-1:0]  pix_window;
    logic [PIX_W-1:0]  threshold;
    logic [PIX_W-1:0]  edge_pix;
    logic              edge_bin;
    logic              out_valid;
    logic [ADDR_W-1:0] out_addr;
    logic              frame_done;

    modport master (
        output vsync, in_valid, pix_window, threshold,
        input  edge_pix, edge_bin, out_valid, out_addr, frame_done
    );

    modport slave (
        input  vsync, in_valid, pix_window, threshold,
        output edge_pix, edge_bin, out_valid, out_addr, frame_done
    );
endinterface

// File: rtl/sobel_filter.sv
// ---------------------------------------------------------------------------
// sobel_filter
// Purpose : 3-stage Sobel edge detector on a stream of 3x3 grey windows.
//           Tracks the frame position of each accepted window, forces border
//           pixels to zero, saturates |Gx|+|Gy| to 8 bits and binarises it.
// Ports   : CLK25  - pixel clock
//           reset  - synchronous active-high reset
//           io_bus - sobel_filter_if.slave (window in, edge result out)
// ---------------------------------------------------------------------------
module sobel_filter #(
    parameter int unsigned H_RES = 640,
    parameter int unsigned V_RES = 480
) (
    input  logic          CLK25,
    input  logic          reset,
    sobel_filter_if.slave io_bus
);
    localparam int unsigned PIX_W  = 8;
    localparam int unsigned G_W    = 11;
    localparam int unsigned ADDR_W = 19;
    localparam int unsigned X_W    = $clog2(H_RES);
    localparam int unsigned Y_W    = $clog2(V_RES);
    localparam int unsigned FRAME  = H_RES * V_RES;

    // Position of the centre pixel of the next accepted window
    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic [ADDR_W-1:0] r_addr;

    // Stage 1
    logic              r_v1;
    logic [PIX_W-1:0]  r_nw, r_n, r_ne, r_w, r_e, r_sw, r_s, r_se;
    logic [PIX_W-1:0]  r_thr1;
    logic [ADDR_W-1:0] r_addr1;
    logic              r_border1;

    // Stage 2
    logic              r_v2;
    logic signed [G_W-1:0] r_gx, r_gy;
    logic [PIX_W-1:0]  r_thr2;
    logic [ADDR_W-1:0] r_addr2;
    logic              r_border2;

    // Stage 3 (outputs)
    logic [PIX_W-1:0]  r_edge_pix;
    logic              r_edge_bin;
    logic              r_out_valid;
    logic [ADDR_W-1:0] r_out_addr;
    logic              r_frame_done;

    logic              w_accept;
    logic              w_border;
    logic [G_W-1:0]    w_gx_pos, w_gx_neg, w_gy_pos, w_gy_neg;
    logic [G_W-1:0]    w_abs_gx, w_abs_gy, w_mag;
    logic [PIX_W-1:0]  w_pix;
    logic              w_unused_centre;

    // The centre sample carries no weight in either Sobel kernel
    assign w_unused_centre = ^io_bus.pix_window[39:32];

    assign w_accept = io_bus.in_valid && io_bus.vsync && (r_addr < ADDR_W'(FRAME));
    assign w_border = (r_x == '0) || (r_x == X_W'(H_RES - 1)) ||
                      (r_y == '0) || (r_y == Y_W'(V_RES - 1));

    // Position counters and pipeline valid bits; blanking acts like a reset
    always_ff @(posedge CLK25) begin
        if (reset || !io_bus.vsync) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
        end else begin
            r_v1 <= w_accept;
            r_v2 <= r_v1;
            if (w_accept) begin
                r_addr <= r_addr + ADDR_W'(1);
                if (r_x == X_W'(H_RES - 1)) begin
                    r_x <= '0;
                    r_y <= (r_y == Y_W'(V_RES - 1)) ? '0 : r_y + Y_W'(1);
                end else begin
                    r_x <= r_x + X_W'(1);
                end
            end
        end
    end

    // Stage 1 payload capture
    always_ff @(posedge CLK25) begin
        if (w_accept) begin
            {r_nw, r_n, r_ne} <= io_bus.pix_window[71:48];
            r_w               <= io_bus.pix_window[47:40];
            r_e               <= io_bus.pix_window[31:24];
            {r_sw, r_s, r_se} <= io_bus.pix_window[23:0];
            r_thr1            <= io_bus.threshold;
            r_addr1           <= r_addr;
            r_border1         <= w_border;
        end
    end

    // Gradients: positive and negative kernel halves summed separately, the
    // 11-bit difference wraps into the correct two's-complement result
    always_comb begin
        w_gx_pos = G_W'(r_ne) + {2'b00, r_e, 1'b0} + G_W'(r_se);
        w_gx_neg = G_W'(r_nw) + {2'b00, r_w, 1'b0} + G_W'(r_sw);
        w_gy_pos = G_W'(r_sw) + {2'b00, r_s, 1'b0} + G_W'(r_se);
        w_gy_neg = G_W'(r_nw) + {2'b00, r_n, 1'b0} + G_W'(r_ne);
    end

    // Stage 2
    always_ff @(posedge CLK25) begin
        if (r_v1) begin
            r_gx      <= $signed(w_gx_pos - w_gx_neg);
            r_gy      <= $signed(w_gy_pos - w_gy_neg);
            r_thr2    <= r_thr1;
            r_addr2   <= r_addr1;
            r_border2 <= r_border1;
        end
    end

    // Magnitude, saturation and border masking
    always_comb begin
        w_abs_gx = r_gx[G_W-1] ? $unsigned(-r_gx) : $unsigned(r_gx);
        w_abs_gy = r_gy[G_W-1] ? $unsigned(-r_gy) : $unsigned(r_gy);
        w_mag    = w_abs_gx + w_abs_gy;
        w_pix    = (w_mag > G_W'(255)) ? PIX_W'(255) : w_mag[PIX_W-1:0];
        if (r_border2) begin
            w_pix = '0;
        end
    end

    // Stage 3: data outputs hold across bubbles
    always_ff @(posedge CLK25) begin
        if (reset) begin
            r_edge_pix   <= '0;
            r_edge_bin   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_addr   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_out_valid  <= r_v2 && io_bus.vsync;
            r_frame_done <= r_v2 && io_bus.vsync && (r_addr2 == ADDR_W'(FRAME - 1));
            if (r_v2 && io_bus.vsync) begin
                r_edge_pix <= w_pix;
                r_edge_bin <= (w_pix > r_thr2);
                r_out_addr <= r_addr2;
            end
        end
    end

    assign io_bus.edge_pix   = r_edge_pix;
    assign io_bus.edge_bin   = r_edge_bin;
    assign io_bus.out_valid  = r_out_valid;
    assign io_bus.out_addr   = r_out_addr;
    assign io_bus.frame_done = r_frame_done;
endmodule
